regfile_write_arbiter: RTL

- Owns the single write port of the 32x64 register file.
- After reset, sequences a zero-clear of all registers.
- Then shares the write port between two writeback requesters using round-robin arbitration and a valid/ready handshake: A is ALU writeback, B is load/multi-cycle writeback.
- Outputs are registered on posedge clk. The register file commits on the following negedge, so port signals are stable at the commit edge.

---
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner: clears NUM_REGS registers after reset, then round-robins A/B writebacks.
// Latency: accept at posedge N drives RegWrite in cycle N+1; ready is low during init, stall or reset.
module regfile_write_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              stall,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] RD,
   output logic [DATA_W-1:0] WriteData,
   output logic              init_done
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic              GRANT_A  = 1'b0;
   localparam logic              GRANT_B  = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic              last_grant;
   logic              a_xfer, b_xfer;

   always_ff @(posedge clk) begin
      if (!reset) state <= INIT;
      else        state <= state_nxt;
   end

   // Ready is also gated by reset so a request in the reset cycle is never accepted.
   always_comb begin
      state_nxt = state;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      init_done = 1'b0;
      case (state)
         INIT: begin
            if (cnt == LAST_REG) state_nxt = RUN;
         end
         RUN: begin
            init_done = 1'b1;
            a_ready   = reset & !stall & a_valid & (!b_valid | (last_grant == GRANT_B));
            b_ready   = reset & !stall & b_valid & (!a_valid | (last_grant == GRANT_A));
         end
         default: state_nxt = INIT;
      endcase
   end

   assign a_xfer = a_valid & a_ready;
   assign b_xfer = b_valid & b_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt        <= '0;
         RegWrite   <= 1'b0;
         RD         <= '0;
         WriteData  <= '0;
         last_grant <= GRANT_B;
      end else if (state == INIT) begin
         RegWrite  <= 1'b1;
         RD        <= cnt;
         WriteData <= '0;
         cnt       <= cnt + 1'b1;
      end else if (a_xfer) begin
         RegWrite   <= (a_rd != '0);
         RD         <= a_rd;
         WriteData  <= a_data;
         last_grant <= GRANT_A;
      end else if (b_xfer) begin
         RegWrite   <= (b_rd != '0);
         RD         <= b_rd;
         WriteData  <= b_data;
         last_grant <= GRANT_B;
      end else begin
         RegWrite <= 1'b0;
      end
   end

endmodule
